// File: rtl/fifo_playback_ctrl_pkg.sv
// Shared definitions for the FIFO record/playback controller.
//   state_t            : controller states (record plus the three playback phases)
//   tick_period_cycles : converts clock frequency [Hz] and step period [s] into
//                        a whole number of clock cycles, rounded, minimum 1
package fifo_playback_ctrl_pkg;

  typedef enum logic [1:0] {
    REC       = 2'd0,
    PLAY_WAIT = 2'd1,
    PLAY_POP  = 2'd2,
    PLAY_PUSH = 2'd3
  } state_t;

  // Evaluated at elaboration only; the +0.5 before truncation rounds to nearest.
  function automatic int tick_period_cycles(input real clk_hz, input real period_s);
    int n;
    n = $rtoi(clk_hz * period_s + 0.5);
    if (n < 1) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/fifo_playback_ctrl_if.sv
// Handshake bundle between the playback controller and a synchronous FIFO.
//   Fifo_InData/Fifo_InValid/Fifo_InReady    : write side (controller -> FIFO)
//   Fifo_OutData/Fifo_OutValid/Fifo_OutReady : read side  (FIFO -> controller)
// A transfer happens on any cycle where the matching Valid and Ready are both 1.
//   master : controller view
//   slave  : FIFO view
interface fifo_playback_ctrl_if #(
  parameter int Width_g = 4
);

  logic [Width_g-1:0] Fifo_InData;
  logic               Fifo_InValid;
  logic               Fifo_InReady;
  logic [Width_g-1:0] Fifo_OutData;
  logic               Fifo_OutValid;
  logic               Fifo_OutReady;

  modport master (
    output Fifo_InData,
    output Fifo_InValid,
    output Fifo_OutReady,
    input  Fifo_InReady,
    input  Fifo_OutData,
    input  Fifo_OutValid
  );

  modport slave (
    input  Fifo_InData,
    input  Fifo_InValid,
    input  Fifo_OutReady,
    output Fifo_InReady,
    output Fifo_OutData,
    output Fifo_OutValid
  );

endinterface

// File: rtl/fifo_playback_tick.sv
// Free-running playback step timer.
//   Clk  : clock, rising edge
//   Rst  : synchronous active-high reset
//   Clr  : holds the counter at zero (first Tick then follows one full period)
//   Tick : high for one cycle every tick_period_cycles() cycles
// The counter wraps on its own terminal count, so tick spacing never drifts
// regardless of what the consumer does between ticks.
module fifo_playback_tick
  import fifo_playback_ctrl_pkg::*;
#(
  parameter real ClkFrequency_g   = 125.0e6,
  parameter real PlaybackPeriod_g = 0.5
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Clr,
  output logic Tick
);

  localparam int PeriodC = tick_period_cycles(ClkFrequency_g, PlaybackPeriod_g);
  localparam int CntW    = (PeriodC > 1) ? $clog2(PeriodC) : 1;
  localparam logic [CntW-1:0] LastC = CntW'(PeriodC - 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Rst || Clr) begin
      cnt <= '0;
    end else if (cnt == LastC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign Tick = (cnt == LastC) && !Clr;

endmodule

// File: rtl/fifo_playback_ctrl.sv
// Record/playback controller in front of a synchronous FIFO.
//   Clk, Rst                    : clock (rising edge), synchronous active-high reset
//   Data_In                     : value written on Push_Evt while recording
//   Push_Evt/Pop_Evt/Mode_Evt   : single-cycle event pulses
//   fifo (master)               : FIFO write and read handshakes
//   Led                         : displayed value (FIFO head in REC, last step in playback)
//   Mode                        : 0 = record, 1 = playback
//   Dropped                     : one-cycle pulse when a push hits a full FIFO
// In playback, every tick pops the head and pushes it back to the tail, so the
// FIFO contents rotate by one entry per step. The pop always precedes the push,
// so a full FIFO rotates without losing anything.
module fifo_playback_ctrl
  import fifo_playback_ctrl_pkg::*;
#(
  parameter int  Width_g          = 4,
  parameter real ClkFrequency_g   = 125.0e6,
  parameter real PlaybackPeriod_g = 0.5
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [Width_g-1:0] Data_In,
  input  logic               Push_Evt,
  input  logic               Pop_Evt,
  input  logic               Mode_Evt,
  fifo_playback_ctrl_if.master fifo,
  output logic [Width_g-1:0] Led,
  output logic               Mode,
  output logic               Dropped
);

  state_t             state, state_nxt;
  logic               mode_pend, mode_pend_nxt;
  logic [Width_g-1:0] hold, hold_nxt;
  logic [Width_g-1:0] led_nxt;
  logic               tick;
  logic               tick_clr;

  // Timer is held cleared throughout REC so the first step after entering
  // playback is one full period away.
  assign tick_clr = (state == REC);

  fifo_playback_tick #(
    .ClkFrequency_g   (ClkFrequency_g),
    .PlaybackPeriod_g (PlaybackPeriod_g)
  ) u_tick (
    .Clk  (Clk),
    .Rst  (Rst),
    .Clr  (tick_clr),
    .Tick (tick)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= REC;
      mode_pend <= 1'b0;
      hold      <= '0;
      Led       <= '0;
    end else begin
      state     <= state_nxt;
      mode_pend <= mode_pend_nxt;
      hold      <= hold_nxt;
      Led       <= led_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    mode_pend_nxt      = mode_pend;
    hold_nxt           = hold;
    led_nxt            = Led;
    fifo.Fifo_InData   = Data_In;
    fifo.Fifo_InValid  = 1'b0;
    fifo.Fifo_OutReady = 1'b0;
    Dropped            = 1'b0;

    case (state)
      REC: begin
        // Push and pop are independent and may both fire in one cycle.
        fifo.Fifo_InValid  = Push_Evt;
        fifo.Fifo_OutReady = Pop_Evt;
        Dropped            = Push_Evt & ~fifo.Fifo_InReady;
        led_nxt            = fifo.Fifo_OutValid ? fifo.Fifo_OutData : '0;
        mode_pend_nxt      = 1'b0;
        if (Mode_Evt) state_nxt = PLAY_WAIT;
      end

      PLAY_WAIT: begin
        // A pending mode change wins over a coincident tick: no half rotation.
        if (Mode_Evt || mode_pend) begin
          state_nxt     = REC;
          mode_pend_nxt = 1'b0;
        end else if (tick) begin
          if (fifo.Fifo_OutValid) begin
            fifo.Fifo_OutReady = 1'b1;
            led_nxt            = fifo.Fifo_OutData;
            hold_nxt           = fifo.Fifo_OutData;
            state_nxt          = PLAY_POP;
          end else begin
            led_nxt = '0;
          end
        end
      end

      PLAY_POP: begin
        // Gap cycle so the FIFO's registered ready reflects the pop before re-push.
        if (Mode_Evt) mode_pend_nxt = 1'b1;
        state_nxt = PLAY_PUSH;
      end

      PLAY_PUSH: begin
        fifo.Fifo_InData  = hold;
        fifo.Fifo_InValid = 1'b1;
        if (Mode_Evt) mode_pend_nxt = 1'b1;
        if (fifo.Fifo_InReady) state_nxt = PLAY_WAIT;
      end

      default: begin
        state_nxt = REC;
      end
    endcase

    // Handshake strobes are silenced during reset; the FIFO is reset alongside.
    if (Rst) begin
      fifo.Fifo_InValid  = 1'b0;
      fifo.Fifo_OutReady = 1'b0;
      Dropped            = 1'b0;
    end
  end

  assign Mode = (state != REC) && !Rst;

endmodule

// File: doc/fifo_playback_ctrl.md
FIFO_PLAYBACK_CTRL -- requirements
Module: fifo_playback_ctrl

Interface
REQ-001 Generic Width_g, default 4: data width of FIFO entries and of Data_In and Led.
REQ-002 Generic ClkFrequency_g, default 125.0e6: clock frequency in Hz.
REQ-003 Generic PlaybackPeriod_g, default 0.5: playback step period in seconds.
REQ-004 Port Clk  in  1  clock; all logic SHALL be rising-edge Clk.
REQ-005 Port Rst  in  1  reset, synchronous, active-high.
REQ-006 Port Data_In  in  Width_g  data pushed on Push_Evt (already synchronised).
REQ-007 Port Push_Evt / Pop_Evt / Mode_Evt  in  1 each  single-cycle event pulses.
REQ-008 Port Fifo_InData  out  Width_g; Fifo_InValid  out  1; Fifo_InReady  in  1: FIFO write handshake.
REQ-009 Port Fifo_OutData  in  Width_g; Fifo_OutValid  in  1; Fifo_OutReady  out  1: FIFO read handshake.
REQ-010 Port Led  out  Width_g  displayed value; Mode  out  1  (0 = record, 1 = playback); Dropped  out  1  one-cycle pulse on a rejected push.

Function
REQ-011 States SHALL be REC, PLAY_WAIT, PLAY_POP and PLAY_PUSH.
REQ-012 A transfer SHALL occur on a cycle where Valid and Ready are both high.
REQ-013 REC, Push_Evt with Fifo_InReady=1: Fifo_InValid high for exactly that cycle, Fifo_InData=Data_In.
REQ-014 REC, Push_Evt with Fifo_InReady=0 (full): no write, and Dropped SHALL pulse the same cycle.
REQ-015 REC, Pop_Evt: Fifo_OutReady high for exactly that cycle; with Fifo_OutValid=0 (empty) it SHALL have no effect.
REQ-016 REC: Led SHALL equal Fifo_OutData registered one cycle, or 0 when Fifo_OutValid=0.
REQ-017 Simultaneous Push_Evt and Pop_Evt in REC SHALL both be executed in the same cycle.
REQ-018 Mode_Evt in REC: next state PLAY_WAIT; the tick counter SHALL clear so the first step follows one full period.
REQ-019 Tick period SHALL be round(ClkFrequency_g*PlaybackPeriod_g) cycles, minimum 1; the counter SHALL wrap with no drift.
REQ-020 PLAY_WAIT on tick with Fifo_OutValid=1: register Fifo_OutData into Led and into a hold register, assert Fifo_OutReady one cycle, go to PLAY_POP.
REQ-021 PLAY_WAIT on tick with Fifo_OutValid=0: Led SHALL be 0 and the state SHALL remain PLAY_WAIT.
REQ-022 PLAY_POP: the state SHALL advance to PLAY_PUSH after one cycle.
REQ-023 PLAY_PUSH: Fifo_InValid=1 and Fifo_InData=hold register until Fifo_InReady=1, then PLAY_WAIT; net FIFO contents rotate by one and no entry is lost.
REQ-024 Push_Evt and Pop_Evt SHALL be ignored in every PLAY_* state.
REQ-025 Mode_Evt in PLAY_WAIT: next state REC.
REQ-026 Mode_Evt in PLAY_POP/PLAY_PUSH SHALL be latched as pending and taken on the return to PLAY_WAIT (one cycle in PLAY_WAIT, then REC).
REQ-027 Mode SHALL be 1 in every PLAY_* state and 0 in REC.
REQ-028 Fifo_InValid and Fifo_OutReady SHALL never be high together in PLAY_* states.

Reset
REQ-029 Rst=1: state REC, Led=0, Mode=0, Dropped=0, Fifo_InValid=0, Fifo_OutReady=0, tick counter=0, pending mode flag=0, hold register=0.
REQ-030 Rst mid-rotation (PLAY_POP/PLAY_PUSH) SHALL abandon the re-push; the FIFO is reset by the same Rst, so no inconsistency remains.

Structure
REQ-031 A shared package SHALL hold the state enumeration and the function that computes the tick period in cycles.
REQ-032 One sub-module SHALL be used: the period tick generator fifo_playback_tick (generics ClkFrequency_g and PlaybackPeriod_g; ports Clk, Rst, Clr, Tick).
REQ-033 The controller SHALL drive a synchronous FIFO directly, with no combinational path from Fifo_InReady to Fifo_OutReady.

Verification (ClkFrequency_g=100, PlaybackPeriod_g=0.05, i.e. 5 cycles; FIFO depth 4)
REQ-034 REC, push 0x3, 0x5, 0xA -> FIFO holds 3 entries; Led=0x3 one cycle after the first write.
REQ-035 REC, 5 pushes into full depth-4 FIFO -> 5th write rejected, Dropped pulses once, contents 4 entries unchanged.
REQ-036 Pop_Evt on empty FIFO -> no handshake, Led=0; simultaneous Push_Evt 0x7 and Pop_Evt with 1 entry -> count unchanged, Led shows new head.
REQ-037 Playback with entries 1,2,3 -> Led sequence 1,2,3,1,2 with steps exactly 5 cycles apart; FIFO count stays 3.
REQ-038 Playback on full FIFO -> rotation completes (pop before push), no Dropped pulse, count stays 4.
REQ-039 Mode_Evt during PLAY_PUSH -> push completes, REC entered 2 cycles later, FIFO count intact; Rst in PLAY_POP -> all outputs at reset values next cycle.
